// File: rtl/toggle_port_bram_if.sv
// One requester's side of the toggle request/acknowledge memory port.
// A request is pending while req differs from ack; q is valid when ack toggles.
interface toggle_port_bram_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] a;
  logic [1:0]        ds;
  logic              we;
  logic [15:0]       d;
  logic [15:0]       q;

  modport master (output req, a, ds, we, d, input ack, q);
  modport slave  (input req, a, ds, we, d, output ack, q);
endinterface

// File: rtl/toggle_port_bram.sv
// Two-port toggle-handshake responder backed by an on-chip 16-bit word RAM with
// programmable ack latency. Define RR_ARB_EN for round-robin arbitration (default: port1 priority).
module toggle_port_bram #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 4
) (
  input logic                clk,
  input logic                reset,
  toggle_port_bram_if.slave  port1,
  toggle_port_bram_if.slave  port2
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_sel;
  logic              r_ack1;
  logic              r_ack2;
  logic [15:0]       r_q1;
  logic [15:0]       r_q2;
  logic [ADDR_W-1:0] r_a;
  logic              r_we;
  logic [1:0]        r_ds;
  logic [15:0]       r_d;
  logic [15:0]       r_rdata;
  logic [15:0]       r_mem [0:(2**ADDR_W)-1];

  logic w_pend1;
  logic w_pend2;
  logic w_grant2;
  logic w_access;

  assign w_pend1  = port1.req ^ r_ack1;
  assign w_pend2  = port2.req ^ r_ack2;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef RR_ARB_EN
  logic r_rr_p2;
  assign w_grant2 = w_pend2 && (!w_pend1 || r_rr_p2);
`else
  assign w_grant2 = w_pend2 && !w_pend1;
`endif

  assign port1.ack = r_ack1;
  assign port2.ack = r_ack2;
  assign port1.q   = r_q1;
  assign port2.q   = r_q2;

  // Control: grant, latency countdown, ack toggle and read-data return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_sel   <= 1'b0;
      r_ack1  <= 1'b0;
      r_ack2  <= 1'b0;
      r_q1    <= 16'h0000;
      r_q2    <= 16'h0000;
`ifdef RR_ARB_EN
      r_rr_p2 <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pend1 || w_pend2) begin
            r_sel   <= w_grant2;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= S_WAIT;
`ifdef RR_ARB_EN
            r_rr_p2 <= !w_grant2;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACK;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACK: begin
          if (!r_sel) begin
            r_ack1 <= ~r_ack1;
            if (!r_we) r_q1 <= r_rdata;
          end else begin
            r_ack2 <= ~r_ack2;
            if (!r_we) r_q2 <= r_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working copy of the granted request; later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && (w_pend1 || w_pend2)) begin
      r_a  <= w_grant2 ? port2.a  : port1.a;
      r_we <= w_grant2 ? port2.we : port1.we;
      r_ds <= w_grant2 ? port2.ds : port1.ds;
      r_d  <= w_grant2 ? port2.d  : port1.d;
    end
  end

  // RAM access: a write whose countdown has expired commits even on a reset edge
  always_ff @(posedge clk) begin
    if (w_access) begin
      if (r_we) begin
        if (r_ds[1]) r_mem[r_a][15:8] <= r_d[15:8];
        if (r_ds[0]) r_mem[r_a][7:0]  <= r_d[7:0];
      end else begin
        r_rdata <= r_mem[r_a];
      end
    end
  end

endmodule

// File: tb/tb_toggle_port_bram.sv
// Directed bench for toggle_port_bram (LATENCY=4): stimulus pushes expected acks,
// a monitor pops and checks ack timing and returned data.
module tb_toggle_port_bram;

  localparam int ADDR_W = 15;
  localparam int LAT    = 4;
  localparam int REL    = LAT + 2;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb1[$];
  exp_t sb2[$];
  logic [15:0] last_q1 = 16'h0;
  logic [15:0] last_q2 = 16'h0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  toggle_port_bram_if #(.ADDR_W(ADDR_W)) if1 ();
  toggle_port_bram_if #(.ADDR_W(ADDR_W)) if2 ();

  toggle_port_bram #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .port1 (if1),
    .port2 (if2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic on_ack(input int p, input logic [15:0] q);
    exp_t e;
    checks++;
    if ((p == 1 && sb1.size() == 0) || (p == 2 && sb2.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_ack port%0d: ack toggled at cycle %0d, none expected", p, cyc);
      return;
    end
    e = (p == 1) ? sb1.pop_front() : sb2.pop_front();
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL ack_time port%0d: got cycle %0d expected cycle %0d", p, cyc, e.cyc);
    end
    chk($sformatf("ack_q port%0d", p), q, e.q);
  endtask

  // Monitor: samples just after each active edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev1 = if1.ack;
      prev2 = if2.ack;
    end else begin
      if (if1.ack !== prev1) begin prev1 = if1.ack; on_ack(1, if1.q); end
      if (if2.ack !== prev2) begin prev2 = if2.ack; on_ack(2, if2.q); end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ack(input int p, input bit we, input logic [15:0] rd, input int rel);
    exp_t e;
    if (p == 1) begin
      if (!we) last_q1 = rd;
      e.q = last_q1; e.cyc = cyc + rel; sb1.push_back(e);
    end else begin
      if (!we) last_q2 = rd;
      e.q = last_q2; e.cyc = cyc + rel; sb2.push_back(e);
    end
  endtask

  // Drive one request; rd is the hand-computed read result (ignored for writes)
  task automatic issue(input int p, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [1:0] ds, input logic [15:0] d,
                       input logic [15:0] rd, input int rel, input bit push);
    if (p == 1) begin
      if1.we = we; if1.a = a; if1.ds = ds; if1.d = d; if1.req = ~if1.req;
    end else begin
      if2.we = we; if2.a = a; if2.ds = ds; if2.d = d; if2.req = ~if2.req;
    end
    if (push) expect_ack(p, we, rd, rel);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " port1_ack"}, {15'h0, if1.ack}, 16'h0);
    chk({tag, " port2_ack"}, {15'h0, if2.ack}, 16'h0);
    chk({tag, " port1_q"}, if1.q, 16'h0);
    chk({tag, " port2_q"}, if2.q, 16'h0);
  endtask

  initial begin
    if1.req = 1'b0; if1.we = 1'b0; if1.a = '0; if1.ds = 2'b00; if1.d = 16'h0;
    if2.req = 1'b0; if2.we = 1'b0; if2.a = '0; if2.ds = 2'b00; if2.d = 16'h0;
    rst = 1'b1;
    step(3);
    check_reset_state("reset");
    rst = 1'b0;
    step(1);

    // Write then read on port1
    issue(1, 1'b1, 15'h0123, 2'b11, 16'hBEEF, 16'h0, REL, 1'b1); step(REL);
    issue(1, 1'b0, 15'h0123, 2'b00, 16'h0,    16'hBEEF, REL, 1'b1); step(REL);

    // Byte lanes on port2, read back on port1
    issue(2, 1'b1, 15'h0010, 2'b11, 16'h1234, 16'h0, REL, 1'b1); step(REL);
    issue(2, 1'b1, 15'h0010, 2'b10, 16'hAB55, 16'h0, REL, 1'b1); step(REL);
    issue(1, 1'b0, 15'h0010, 2'b00, 16'h0,    16'hAB34, REL, 1'b1); step(REL);

    // Cross-port visibility, then same-edge write (port1) and read (port2)
    issue(1, 1'b1, 15'h0020, 2'b11, 16'h1111, 16'h0, REL, 1'b1); step(REL);
    issue(2, 1'b0, 15'h0020, 2'b00, 16'h0,    16'h1111, REL, 1'b1); step(REL);
    issue(1, 1'b1, 15'h0030, 2'b11, 16'hCAFE, 16'h0, REL, 1'b1);
    issue(2, 1'b0, 15'h0030, 2'b00, 16'h0,    16'hCAFE, 2 * REL, 1'b1);
    step(2 * REL);

    // Both pending; port1 re-requests on the edge its ack lands
    issue(1, 1'b0, 15'h0123, 2'b00, 16'h0, 16'hBEEF, REL, 1'b1);
    issue(2, 1'b0, 15'h0010, 2'b00, 16'h0, 16'hAB34, RR ? 2 * REL : 3 * REL, 1'b1);
    step(REL);
    issue(1, 1'b0, 15'h0020, 2'b00, 16'h0, 16'h1111, RR ? 2 * REL : REL, 1'b1);
    step(2 * REL + 2);

    // Double toggle on port1 while port2's write is in flight; port2 inputs change after grant
    issue(2, 1'b1, 15'h0040, 2'b11, 16'h7777, 16'h0, REL, 1'b1);
    step(1);
    if2.d = 16'h0000; if2.a = 15'h0041;
    if1.req = ~if1.req;
    step(1);
    if1.req = ~if1.req;
    step(REL);
    issue(1, 1'b0, 15'h0040, 2'b00, 16'h0, 16'h7777, REL, 1'b1); step(REL);

    // ds=00 write is a no-op that still acks
    issue(1, 1'b1, 15'h0040, 2'b00, 16'h0000, 16'h0, REL, 1'b1); step(REL);
    issue(1, 1'b0, 15'h0040, 2'b00, 16'h0,    16'h7777, REL, 1'b1); step(REL);

    // Reset mid-WAIT abandons port2's write
    rst = 1'b1; if1.req = 1'b0; if2.req = 1'b0;
    last_q1 = 16'h0; last_q2 = 16'h0;
    step(2);
    rst = 1'b0;
    step(1);
    issue(2, 1'b1, 15'h0020, 2'b11, 16'h5A5A, 16'h0, REL, 1'b0);
    step(2);
    rst = 1'b1;
    if2.we = 1'b0; if2.a = 15'h0020;
    step(2);
    check_reset_state("midwait_reset");
    rst = 1'b0;
    expect_ack(2, 1'b0, 16'h1111, REL);
    step(3 * REL);

    chk("sb1_drained", 16'(sb1.size()), 16'h0);
    chk("sb2_drained", 16'(sb2.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
